fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Producer side of the fetch/decode pipeline latch.
- Owns the PC and runs a variable-latency instruction-memory read handshake.
- Each cycle, drives the latch's data inputs (instruction, PC+2) and its control inputs (freeze, clear).
- Honours decode-side stall, halt, and branch/jump redirects from later stages.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0800, encoding driven into the latch as a bubble.

Ports:
- clk  in  1  clock
- global_rst  in  1  asynchronous, active-high reset
- stall_in  in  1  hazard unit: decode cannot accept a new instruction this cycle
- halt_in  in  1  decode saw HALT; stop fetching
- redirect_valid  in  1  taken branch/jump/exception from a later stage
- redirect_PC  in  16  redirect target
- imem_rd  out  1  read request, held high until imem_done
- imem_addr  out  16  read address (current PC)
- imem_data  in  16  read data, valid only when imem_done=1
- imem_done  in  1  single-cycle completion pulse
- instr_FD_in  out  16  instruction to latch
- inc_PC_FD_in  out  16  PC of that instruction + 2
- freeze_FD  out  1  hold the latch contents
- clr_FD  out  1  flush the latch (local clear)
- PC_out  out  16  current PC (debug)
- halted  out  1  fetch stopped

Behaviour:
- Interface: one clock (clk); reset (global_rst) is asynchronous and active-high.
- Reset values:
  - State = FETCH, PC = RESET_PC, hold buffer = NOP_INSTR / RESET_PC+2.
  - halted = 0, imem_rd = 0 during reset.
- States:
  - FETCH: read outstanding or issuing.
  - HOLD: instruction captured, waiting for stall_in to drop.
  - SQUASH: outstanding read must be discarded.
  - HALTED.
- FETCH:
  - imem_rd = 1, imem_addr = PC.
  - imem_done=1 and stall_in=0:
    - instr_FD_in = imem_data, inc_PC_FD_in = PC+2, freeze_FD = 0.
    - PC <= PC+2, stay in FETCH (back-to-back fetch next cycle).
  - imem_done=1 and stall_in=1:
    - Capture data and PC+2 into the hold buffer.
    - freeze_FD = 1, PC <= PC+2, go to HOLD.
  - imem_done=0:
    - stall_in=0: drive the bubble (NOP_INSTR, freeze_FD = 0).
    - stall_in=1: freeze_FD = 1.
- HOLD:
  - imem_rd = 0; drive the hold buffer to the latch.
  - freeze_FD = stall_in.
  - When stall_in=0: latch accepts the buffer this cycle, go to FETCH.
- Redirect (highest priority, any state except mid-reset):
  - clr_FD = 1 combinationally in that cycle; freeze_FD = 0.
  - PC <= redirect_PC; hold buffer invalidated; halted <= 0.
  - If a read is outstanding (FETCH with imem_done=0) go to SQUASH, otherwise go to FETCH.
  - Redirect overrides stall_in and halt_in in the same cycle.
- SQUASH:
  - imem_rd stays 1 with the old address until imem_done.
  - Data is discarded; the bubble is driven; then go to FETCH with the new PC.
  - A further redirect while in SQUASH updates the PC; stay in SQUASH.
- halt_in (no redirect):
  - From any state: go to HALTED once the current read completes. Data is discarded when in FETCH; halt_in wins over stall_in.
  - HALTED: imem_rd = 0, freeze_FD = 1, halted = 1.
  - Only reset or redirect leaves HALTED.
- PC arithmetic:
  - 16-bit unsigned; 16'hFFFE + 2 wraps to 16'h0000 without error.
  - inc_PC_FD_in uses the same wrap.
- No combinational path from imem_data to imem_rd or imem_addr.
- Reset asserted mid-read: the read is abandoned. Memory must tolerate imem_rd dropping.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - Adds output err_misalign (1 bit, reset 0).
  - When a redirect_PC with bit0 = 1 is accepted: err_misalign <= 1 (sticky until reset), go to HALTED, no read issued.
- Undefined:
  - Port absent; bit0 of the PC is forced to 0 on redirect.

Test Plan:
- Reset, imem_done every cycle, no stalls: imem_addr = 0000, 0002, 0004 on consecutive cycles; inc_PC_FD_in = 0002, 0004, 0006; freeze_FD = 0 throughout.
- imem_done delayed 3 cycles at PC=0004 with stall_in=0: three NOP_INSTR bubbles with freeze_FD = 0; then the instruction with inc_PC_FD_in = 0006.
- Done with stall_in high for 2 cycles: state HOLD, freeze_FD = 1 for 2 cycles; buffered instr/0006 presented the cycle stall_in drops; next read at 0006.
- redirect_valid with redirect_PC = 0x0100 during an outstanding read: clr_FD = 1 that cycle; returning data discarded; next imem_addr = 0x0100.
- halt_in at PC = 0x0010: halted = 1, imem_rd = 0 forever; then redirect to 0x0020 resumes with halted = 0 and imem_addr = 0x0020.
- PC = FFFE, done: inc_PC_FD_in = 0000, next imem_addr = 0000. With FETCH_ALIGN_CHECK_EN, redirect to 0x0101 gives err_misalign = 1, halted = 1.

Source files
------------

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory read handshake.
// The master holds imem_rd until the slave pulses imem_done.
interface fetch_stage_if;
   logic        imem_rd;
   logic [15:0] imem_addr;
   logic [15:0] imem_data;
   logic        imem_done;

   modport master (
      output imem_rd,
      output imem_addr,
      input  imem_data,
      input  imem_done
   );

   modport slave (
      input  imem_rd,
      input  imem_addr,
      output imem_data,
      output imem_done
   );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner and imem read sequencer feeding the F/D latch.
// Optional FETCH_ALIGN_CHECK_EN adds err_misalign on odd redirect targets.
module fetch_stage #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] NOP_INSTR = 16'h0800
) (
   input  logic          clk,
   input  logic          global_rst,
   input  logic          stall_in,
   input  logic          halt_in,
   input  logic          redirect_valid,
   input  logic [15:0]   redirect_PC,
   fetch_stage_if.master imem,
   output logic [15:0]   instr_FD_in,
   output logic [15:0]   inc_PC_FD_in,
   output logic          freeze_FD,
   output logic          clr_FD,
   output logic [15:0]   PC_out,
   output logic          halted
`ifdef FETCH_ALIGN_CHECK_EN
   ,
   output logic          err_misalign
`endif
);

   localparam logic [1:0] S_FETCH  = 2'd0;
   localparam logic [1:0] S_HOLD   = 2'd1;
   localparam logic [1:0] S_SQUASH = 2'd2;
   localparam logic [1:0] S_HALTED = 2'd3;

   logic [1:0]  state, state_nx;
   logic [15:0] pc, pc_nx;
   logic [15:0] sq_addr, sq_addr_nx;
   logic [15:0] hold_instr, hold_instr_nx;
   logic [15:0] hold_inc, hold_inc_nx;
   logic [15:0] pc_inc;
   logic [15:0] rd_target;
   logic        bad_target;
   logic        rd;
   logic        pending;

   assign pc_inc = pc + 16'd2;

`ifdef FETCH_ALIGN_CHECK_EN
   assign rd_target  = redirect_PC;
   assign bad_target = redirect_PC[0];
`else
   assign rd_target  = {redirect_PC[15:1], 1'b0};
   assign bad_target = 1'b0;
`endif

   // A read is in flight whenever imem_rd is high and done has not arrived.
   assign pending = (state == S_FETCH || state == S_SQUASH) &&
                    !imem.imem_done;

   always_comb begin
      state_nx      = state;
      pc_nx         = pc;
      sq_addr_nx    = sq_addr;
      hold_instr_nx = hold_instr;
      hold_inc_nx   = hold_inc;
      rd            = 1'b0;
      imem.imem_addr = pc;
      instr_FD_in   = NOP_INSTR;
      inc_PC_FD_in  = pc_inc;
      freeze_FD     = 1'b0;
      clr_FD        = 1'b0;

      unique case (state)
         S_FETCH: begin
            rd = 1'b1;
            if (imem.imem_done) begin
               if (halt_in) begin
                  freeze_FD = 1'b1;
                  state_nx  = S_HALTED;
               end else if (stall_in) begin
                  freeze_FD     = 1'b1;
                  hold_instr_nx = imem.imem_data;
                  hold_inc_nx   = pc_inc;
                  pc_nx         = pc_inc;
                  state_nx      = S_HOLD;
               end else begin
                  instr_FD_in = imem.imem_data;
                  pc_nx       = pc_inc;
               end
            end else begin
               freeze_FD = stall_in | halt_in;
            end
         end
         S_HOLD: begin
            instr_FD_in  = hold_instr;
            inc_PC_FD_in = hold_inc;
            if (halt_in) begin
               freeze_FD = 1'b1;
               state_nx  = S_HALTED;
            end else begin
               freeze_FD = stall_in;
               if (!stall_in) state_nx = S_FETCH;
            end
         end
         S_SQUASH: begin
            rd             = 1'b1;
            imem.imem_addr = sq_addr;
            freeze_FD      = stall_in | halt_in;
            if (imem.imem_done)
               state_nx = halt_in ? S_HALTED : S_FETCH;
         end
         S_HALTED: begin
            freeze_FD = 1'b1;
         end
      endcase

      if (redirect_valid) begin
         clr_FD        = 1'b1;
         freeze_FD     = 1'b0;
         instr_FD_in   = NOP_INSTR;
         pc_nx         = rd_target;
         hold_instr_nx = NOP_INSTR;
         hold_inc_nx   = RESET_PC + 16'd2;
         if (bad_target) begin
            state_nx = S_HALTED;
         end else if (pending) begin
            state_nx = S_SQUASH;
            if (state == S_FETCH) sq_addr_nx = pc;
         end else begin
            state_nx = S_FETCH;
         end
      end
   end

   always_ff @(posedge clk or posedge global_rst) begin
      if (global_rst) begin
         state      <= S_FETCH;
         pc         <= RESET_PC;
         sq_addr    <= RESET_PC;
         hold_instr <= NOP_INSTR;
         hold_inc   <= RESET_PC + 16'd2;
      end else begin
         state      <= state_nx;
         pc         <= pc_nx;
         sq_addr    <= sq_addr_nx;
         hold_instr <= hold_instr_nx;
         hold_inc   <= hold_inc_nx;
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   always_ff @(posedge clk or posedge global_rst) begin
      if (global_rst)
         err_misalign <= 1'b0;
      else if (redirect_valid && bad_target)
         err_misalign <= 1'b1;
   end
`endif

   // Reset abandons any read in flight.
   assign imem.imem_rd = rd & ~global_rst;
   assign PC_out       = pc;
   assign halted       = (state == S_HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven cycle vectors through a scoreboard queue,
// plus hand sequences for reset mid-read and odd redirect targets.
module tb_fetch_stage;

   localparam logic [15:0] NOP = 16'h0800;
   localparam int          NV  = 31;

   typedef struct {
      logic        stall;
      logic        halt;
      logic        redir;
      logic [15:0] rpc;
      logic        done;
      logic [15:0] data;
      logic        rd;
      logic [15:0] addr;
      logic [15:0] instr;
      logic [15:0] inc;
      logic        frz;
      logic        clr;
      logic        hlt;
   } vec_t;

   logic        clk = 1'b0;
   logic        global_rst;
   logic        stall_in;
   logic        halt_in;
   logic        redirect_valid;
   logic [15:0] redirect_PC;
   logic [15:0] instr_FD_in;
   logic [15:0] inc_PC_FD_in;
   logic        freeze_FD;
   logic        clr_FD;
   logic [15:0] PC_out;
   logic        halted;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        err_misalign;
`endif

   fetch_stage_if bus();

   fetch_stage dut (
      .clk(clk),
      .global_rst(global_rst),
      .stall_in(stall_in),
      .halt_in(halt_in),
      .redirect_valid(redirect_valid),
      .redirect_PC(redirect_PC),
      .imem(bus),
      .instr_FD_in(instr_FD_in),
      .inc_PC_FD_in(inc_PC_FD_in),
      .freeze_FD(freeze_FD),
      .clr_FD(clr_FD),
      .PC_out(PC_out),
      .halted(halted)
`ifdef FETCH_ALIGN_CHECK_EN
      ,
      .err_misalign(err_misalign)
`endif
   );

   always #5 clk = ~clk;

   int   n_tests = 0;
   int   n_fail  = 0;
   vec_t tbl[NV];
   vec_t sb[$];

   function automatic vec_t mk(
      input logic s, input logic h, input logic r,
      input logic [15:0] rp, input logic d, input logic [15:0] dt,
      input logic erd, input logic [15:0] ea, input logic [15:0] ei,
      input logic [15:0] ec, input logic ef, input logic ecl,
      input logic eh);
      vec_t v;
      v.stall = s;  v.halt = h;  v.redir = r;
      v.rpc = rp;   v.done = d;  v.data = dt;
      v.rd = erd;   v.addr = ea; v.instr = ei;
      v.inc = ec;   v.frz = ef;  v.clr = ecl;
      v.hlt = eh;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx,
                      input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s [%0d]: got %h expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      stall_in       = v.stall;
      halt_in        = v.halt;
      redirect_valid = v.redir;
      redirect_PC    = v.rpc;
      bus.imem_done  = v.done;
      bus.imem_data  = v.data;
   endtask

   initial begin
      tbl[0]  = mk(0,0,0,16'h0000,1,16'h1111, 1,16'h0000,16'h1111,16'h0002,0,0,0);
      tbl[1]  = mk(0,0,0,16'h0000,1,16'h2222, 1,16'h0002,16'h2222,16'h0004,0,0,0);
      tbl[2]  = mk(0,0,0,16'h0000,0,16'h0000, 1,16'h0004,NOP,16'h0000,0,0,0);
      tbl[3]  = mk(0,0,0,16'h0000,0,16'h0000, 1,16'h0004,NOP,16'h0000,0,0,0);
      tbl[4]  = mk(0,0,0,16'h0000,0,16'h0000, 1,16'h0004,NOP,16'h0000,0,0,0);
      tbl[5]  = mk(0,0,0,16'h0000,1,16'h4444, 1,16'h0004,16'h4444,16'h0006,0,0,0);
      tbl[6]  = mk(1,0,0,16'h0000,1,16'h6666, 1,16'h0006,NOP,16'h0000,1,0,0);
      tbl[7]  = mk(1,0,0,16'h0000,0,16'h0000, 0,16'h0008,16'h6666,16'h0008,1,0,0);
      tbl[8]  = mk(0,0,0,16'h0000,0,16'h0000, 0,16'h0008,16'h6666,16'h0008,0,0,0);
      tbl[9]  = mk(1,0,0,16'h0000,0,16'h0000, 1,16'h0008,NOP,16'h0000,1,0,0);
      tbl[10] = mk(1,0,1,16'h0100,0,16'h0000, 1,16'h0008,NOP,16'h0000,0,1,0);
      tbl[11] = mk(0,0,0,16'h0000,0,16'h0000, 1,16'h0008,NOP,16'h0000,0,0,0);
      tbl[12] = mk(0,0,0,16'h0000,1,16'hDEAD, 1,16'h0008,NOP,16'h0000,0,0,0);
      tbl[13] = mk(0,0,1,16'h0010,1,16'h0101, 1,16'h0100,NOP,16'h0000,0,1,0);
      tbl[14] = mk(0,1,0,16'h0000,0,16'h0000, 1,16'h0010,NOP,16'h0000,1,0,0);
      tbl[15] = mk(0,1,0,16'h0000,1,16'hBBBB, 1,16'h0010,NOP,16'h0000,1,0,0);
      tbl[16] = mk(0,0,0,16'h0000,0,16'h0000, 0,16'h0010,NOP,16'h0000,1,0,1);
      tbl[17] = mk(0,0,0,16'h0000,0,16'h0000, 0,16'h0010,NOP,16'h0000,1,0,1);
      tbl[18] = mk(0,0,1,16'h0020,0,16'h0000, 0,16'h0010,NOP,16'h0000,0,1,1);
      tbl[19] = mk(0,0,0,16'h0000,1,16'h2020, 1,16'h0020,16'h2020,16'h0022,0,0,0);
      tbl[20] = mk(0,0,1,16'h0030,0,16'h0000, 1,16'h0022,NOP,16'h0000,0,1,0);
      tbl[21] = mk(0,0,1,16'hFFFE,0,16'h0000, 1,16'h0022,NOP,16'h0000,0,1,0);
      tbl[22] = mk(0,0,0,16'h0000,1,16'h9999, 1,16'h0022,NOP,16'h0000,0,0,0);
      tbl[23] = mk(0,0,0,16'h0000,1,16'h7777, 1,16'hFFFE,16'h7777,16'h0000,0,0,0);
      tbl[24] = mk(0,0,0,16'h0000,1,16'h1234, 1,16'h0000,16'h1234,16'h0002,0,0,0);
      tbl[25] = mk(1,0,0,16'h0000,1,16'h5555, 1,16'h0002,NOP,16'h0000,1,0,0);
      tbl[26] = mk(1,1,0,16'h0000,0,16'h0000, 0,16'h0004,NOP,16'h0000,1,0,0);
      tbl[27] = mk(0,0,0,16'h0000,0,16'h0000, 0,16'h0004,NOP,16'h0000,1,0,1);
      tbl[28] = mk(1,1,1,16'h0040,0,16'h0000, 0,16'h0004,NOP,16'h0000,0,1,1);
      tbl[29] = mk(0,0,0,16'h0000,1,16'h4040, 1,16'h0040,16'h4040,16'h0042,0,0,0);
      tbl[30] = mk(0,0,0,16'h0000,0,16'h0000, 1,16'h0042,NOP,16'h0000,0,0,0);

      global_rst     = 1'b1;
      stall_in       = 1'b0;
      halt_in        = 1'b0;
      redirect_valid = 1'b0;
      redirect_PC    = 16'h0000;
      bus.imem_done  = 1'b0;
      bus.imem_data  = 16'h0000;

      #3;
      chk("rst_rd", -1, {15'd0, bus.imem_rd}, 16'd0);
      chk("rst_halted", -1, {15'd0, halted}, 16'd0);
      chk("rst_pc", -1, PC_out, 16'h0000);
      chk("rst_clr", -1, {15'd0, clr_FD}, 16'd0);

      @(negedge clk);
      global_rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         vec_t e;
         drive(tbl[i]);
         sb.push_back(tbl[i]);
         #2;
         e = sb.pop_front();
         chk("imem_rd", i, {15'd0, bus.imem_rd}, {15'd0, e.rd});
         chk("imem_addr", i, bus.imem_addr, e.addr);
         chk("freeze_FD", i, {15'd0, freeze_FD}, {15'd0, e.frz});
         chk("clr_FD", i, {15'd0, clr_FD}, {15'd0, e.clr});
         chk("halted", i, {15'd0, halted}, {15'd0, e.hlt});
         if (!e.frz && !e.clr) begin
            chk("instr", i, instr_FD_in, e.instr);
            if (e.instr != NOP)
               chk("inc_pc", i, inc_PC_FD_in, e.inc);
         end
         @(negedge clk);
      end

      // reset in the middle of an outstanding read at 0x0042
      drive(mk(0,0,0,16'h0000,0,16'h0000, 0,0,0,0,0,0,0));
      global_rst = 1'b1;
      #1;
      chk("midrst_rd", 100, {15'd0, bus.imem_rd}, 16'd0);
      chk("midrst_pc", 100, PC_out, 16'h0000);
      chk("midrst_halted", 100, {15'd0, halted}, 16'd0);
      @(negedge clk);
      global_rst = 1'b0;
      #2;
      chk("postrst_rd", 101, {15'd0, bus.imem_rd}, 16'd1);
      chk("postrst_addr", 101, bus.imem_addr, 16'h0000);

      // odd redirect target during an outstanding read
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_PC    = 16'h0101;
      #2;
      chk("odd_clr", 102, {15'd0, clr_FD}, 16'd1);
      @(negedge clk);
      redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      #2;
      chk("odd_err", 103, {15'd0, err_misalign}, 16'd1);
      chk("odd_halted", 103, {15'd0, halted}, 16'd1);
      chk("odd_rd", 103, {15'd0, bus.imem_rd}, 16'd0);
`else
      bus.imem_done = 1'b1;
      #2;
      chk("odd_squash_addr", 103, bus.imem_addr, 16'h0000);
      chk("odd_squash_instr", 103, instr_FD_in, NOP);
      @(negedge clk);
      bus.imem_done = 1'b0;
      #2;
      chk("odd_aligned_addr", 104, bus.imem_addr, 16'h0100);
      chk("odd_rd", 104, {15'd0, bus.imem_rd}, 16'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
